spi_slave_rib_bridge: RTL and testbench

//  SPI target (mode 0, CPOL=0/CPHA=0); the responder end of the SoC's SPI master protocol.

---
 rtl/spi_slave_rib_bridge.sv | 227 ++++++++++++++++++++++
 tb/tb_spi_slave_rib_bridge.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_slave_rib_bridge.sv
// SPI mode-0 target that bridges an external SPI host onto the RIB bus.
// Frame: [cmd 8][addr 32][write: data 32 | read: DUMMY_BITS turnaround, data 32 out].
// SCK/SS/MOSI are oversampled in the clk domain. f_clk must be at least 8x f_sck.
// DUMMY_BITS must be at least 1.
module spi_slave_rib_bridge #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic [7:0]  CMD_WR      = 8'h02,
  parameter logic [7:0]  CMD_RD      = 8'h03,
  parameter int unsigned DUMMY_BITS  = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        spi_clk_i,
  input  logic        spi_ss_i,
  input  logic        spi_mosi_i,
  output logic        spi_miso_o,
  output logic        miso_oe_o,
  output logic        req_o,
  output logic        we_o,
  output logic [31:0] addr_o,
  output logic [31:0] wdata_o,
  input  logic [31:0] rdata_i,
  input  logic        gnt_i,
  output logic        busy_o
);

  typedef enum logic [3:0] {
    S_IDLE, S_CMD, S_ADDR, S_WDATA, S_WREQ,
    S_RREQ, S_DUMMY, S_RDATA, S_DONE, S_IGNORE
  } state_t;

  localparam logic [5:0] DUMMY_CNT  = 6'(DUMMY_BITS);
  localparam logic [5:0] DUMMY_LAST = 6'(DUMMY_BITS - 1);

  logic [SYNC_STAGES-1:0] sck_sync_q, ss_sync_q, mosi_sync_q;
  logic                   sck_prev_q;
  logic                   sck_s, ss_s, mosi_s, sck_rise, sck_fall;

  state_t      state_q;
  logic [5:0]  bitcnt_q;
  logic [7:0]  cmd_q;
  logic        is_rd_q;
  logic [31:0] addr_q, wdata_q, tx_q;
  logic        req_q, we_q, miso_q;
  logic [7:0]  cmd_shift;
  logic        dcnt_inc;
  logic [5:0]  dcnt_next;

  assign sck_s     = sck_sync_q[SYNC_STAGES-1];
  assign ss_s      = ss_sync_q[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
  assign sck_rise  = sck_s & ~sck_prev_q;
  assign sck_fall  = ~sck_s & sck_prev_q;
  assign cmd_shift = {cmd_q[6:0], mosi_s};

  // While waiting for a read grant the dummy SCK rises keep being counted,
  // saturating once the turnaround phase is over.
  assign dcnt_inc  = sck_rise && (bitcnt_q != DUMMY_CNT);
  assign dcnt_next = bitcnt_q + {5'b0, dcnt_inc};

  assign spi_miso_o = miso_q & ~ss_s;
  assign miso_oe_o  = ~ss_s;
  assign req_o      = req_q;
  assign we_o       = we_q;
  assign addr_o     = addr_q;
  assign wdata_o    = wdata_q;
  assign busy_o     = (state_q != S_IDLE);

  // Pin synchronizers and SCK edge history
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sck_sync_q  <= '0;
      ss_sync_q   <= '1;
      mosi_sync_q <= '0;
      sck_prev_q  <= 1'b0;
    end else begin
      sck_sync_q  <= {sck_sync_q[SYNC_STAGES-2:0], spi_clk_i};
      ss_sync_q   <= {ss_sync_q[SYNC_STAGES-2:0], spi_ss_i};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi_i};
      sck_prev_q  <= sck_s;
    end
  end

  // Frame FSM with registered bus and MISO outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      bitcnt_q <= '0;
      cmd_q    <= '0;
      is_rd_q  <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      tx_q     <= '0;
      req_q    <= 1'b0;
      we_q     <= 1'b0;
      miso_q   <= 1'b0;
    end else begin
      miso_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (!ss_s) begin
            state_q  <= S_CMD;
            bitcnt_q <= '0;
          end
        end
        S_CMD: begin
          if (ss_s) begin
            state_q <= S_IDLE;
          end else if (sck_rise) begin
            cmd_q <= cmd_shift;
            if (bitcnt_q == 6'd7) begin
              bitcnt_q <= '0;
              if (cmd_shift == CMD_WR) begin
                is_rd_q <= 1'b0;
                state_q <= S_ADDR;
              end else if (cmd_shift == CMD_RD) begin
                is_rd_q <= 1'b1;
                state_q <= S_ADDR;
              end else begin
                state_q <= S_IGNORE;
              end
            end else begin
              bitcnt_q <= bitcnt_q + 6'd1;
            end
          end
        end
        S_ADDR: begin
          if (ss_s) begin
            state_q <= S_IDLE;
          end else if (sck_rise) begin
            addr_q <= {addr_q[30:0], mosi_s};
            if (bitcnt_q == 6'd31) begin
              bitcnt_q <= '0;
              if (is_rd_q) begin
                state_q <= S_RREQ;
                req_q   <= 1'b1;
                we_q    <= 1'b0;
              end else begin
                state_q <= S_WDATA;
              end
            end else begin
              bitcnt_q <= bitcnt_q + 6'd1;
            end
          end
        end
        S_WDATA: begin
          if (ss_s) begin
            state_q <= S_IDLE;
          end else if (sck_rise) begin
            wdata_q <= {wdata_q[30:0], mosi_s};
            if (bitcnt_q == 6'd31) begin
              bitcnt_q <= '0;
              state_q  <= S_WREQ;
              req_q    <= 1'b1;
              we_q     <= 1'b1;
            end else begin
              bitcnt_q <= bitcnt_q + 6'd1;
            end
          end
        end
        S_WREQ: begin
          if (gnt_i) begin
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            state_q <= ss_s ? S_IDLE : S_DONE;
          end
        end
        S_RREQ: begin
          bitcnt_q <= dcnt_next;
          if (gnt_i) begin
            req_q <= 1'b0;
            tx_q  <= rdata_i;
            if (ss_s) begin
              state_q <= S_IDLE;
            end else if (dcnt_next != DUMMY_CNT) begin
              state_q <= S_DUMMY;
            end else if (dcnt_inc) begin
              // grant coincides with the last dummy rise: data still on time
              state_q  <= S_RDATA;
              bitcnt_q <= '0;
            end else begin
              // turnaround already over: host clocks out zeros
              state_q <= S_DONE;
            end
          end
        end
        S_DUMMY: begin
          if (ss_s) begin
            state_q <= S_IDLE;
          end else if (sck_rise) begin
            if (bitcnt_q == DUMMY_LAST) begin
              bitcnt_q <= '0;
              state_q  <= S_RDATA;
            end else begin
              bitcnt_q <= bitcnt_q + 6'd1;
            end
          end
        end
        S_RDATA: begin
          if (ss_s) begin
            state_q <= S_IDLE;
          end else begin
            miso_q <= miso_q;
            if (sck_fall) begin
              miso_q <= tx_q[31];
              tx_q   <= {tx_q[30:0], 1'b0};
            end
            if (sck_rise) begin
              if (bitcnt_q == 6'd31) begin
                state_q <= S_DONE;
              end else begin
                bitcnt_q <= bitcnt_q + 6'd1;
              end
            end
          end
        end
        S_DONE, S_IGNORE: begin
          if (ss_s) begin
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_slave_rib_bridge.sv
// Directed bench for spi_slave_rib_bridge: table of SPI frames plus corner-case sequences.
module tb_spi_slave_rib_bridge;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        spi_clk = 1'b0;
  logic        spi_ss = 1'b1;
  logic        spi_mosi = 1'b0;
  logic        spi_miso, miso_oe, req, we, gnt, busy;
  logic [31:0] addr, wdata, rdata;

  int unsigned n_chk = 0;
  int unsigned n_fail = 0;

  int unsigned acc_cnt = 0;
  int unsigned req_cyc = 0;
  logic [31:0] mon_addr = '0;
  logic [31:0] mon_wdata = '0;
  logic        mon_we = 1'b0;

  spi_slave_rib_bridge #(
    .SYNC_STAGES(2),
    .CMD_WR     (8'h02),
    .CMD_RD     (8'h03),
    .DUMMY_BITS (8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .spi_clk_i (spi_clk),
    .spi_ss_i  (spi_ss),
    .spi_mosi_i(spi_mosi),
    .spi_miso_o(spi_miso),
    .miso_oe_o (miso_oe),
    .req_o     (req),
    .we_o      (we),
    .addr_o    (addr),
    .wdata_o   (wdata),
    .rdata_i   (rdata),
    .gnt_i     (gnt),
    .busy_o    (busy)
  );

  always #5 clk = ~clk;

  // Bus monitor: counts request cycles and granted accesses
  always @(negedge clk) begin
    if (req) req_cyc++;
    if (req && gnt) begin
      acc_cnt++;
      mon_addr  = addr;
      mon_wdata = wdata;
      mon_we    = we;
    end
  end

  typedef struct {
    logic [7:0]  cmd;
    logic [31:0] addr;
    logic [31:0] data;
    logic [31:0] rdata;
    int unsigned exp_acc;
    logic        exp_we;
    logic [31:0] exp_miso;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, exp);
    end
  endtask

  // One SCK period per bit, MSB first; MISO is sampled just before each rise.
  task automatic send_bits(input logic [31:0] val, input int unsigned n, output logic [31:0] rx);
    rx = '0;
    for (int i = int'(n) - 1; i >= 0; i--) begin
      spi_mosi = val[i];
      #40;
      rx = {rx[30:0], spi_miso};
      spi_clk = 1'b1;
      #40;
      spi_clk = 1'b0;
    end
    spi_mosi = 1'b0;
  endtask

  task automatic run_frame(input logic [7:0] cmd, input logic [31:0] a, input logic [31:0] d,
                           output logic [31:0] dummy_rx, output logic [31:0] rd_rx);
    logic [31:0] junk;
    spi_ss = 1'b0;
    #80;
    send_bits({24'h0, cmd}, 8, junk);
    send_bits(a, 32, junk);
    if (cmd == 8'h03) begin
      send_bits('0, 8, dummy_rx);
      send_bits('0, 32, rd_rx);
    end else begin
      dummy_rx = '0;
      send_bits(d, 32, rd_rx);
    end
    #80;
    spi_ss = 1'b1;
    #200;
  endtask

  task automatic apply_vec(input int unsigned idx);
    logic [31:0] dum, rx;
    int unsigned acc0, req0;
    vec_t v;
    v = vecs[idx];
    @(negedge clk);
    rdata = v.rdata;
    acc0 = acc_cnt;
    req0 = req_cyc;
    run_frame(v.cmd, v.addr, v.data, dum, rx);
    chk($sformatf("v%0d_accesses", idx), acc_cnt - acc0, v.exp_acc);
    chk($sformatf("v%0d_req_cycles", idx), req_cyc - req0, v.exp_acc);
    chk($sformatf("v%0d_busy_after", idx), {31'b0, busy}, 32'h0);
    if (v.exp_acc != 0) begin
      chk($sformatf("v%0d_addr", idx), mon_addr, v.addr);
      chk($sformatf("v%0d_we", idx), {31'b0, mon_we}, {31'b0, v.exp_we});
      if (v.exp_we) begin
        chk($sformatf("v%0d_wdata", idx), mon_wdata, v.data);
      end else begin
        chk($sformatf("v%0d_miso_data", idx), rx, v.exp_miso);
        chk($sformatf("v%0d_miso_dummy", idx), dum, 32'h0);
      end
    end
  endtask

  // Raise SS and count clocks until busy drops (bounded)
  task automatic measure_busy_fall(input string name);
    int unsigned n;
    @(negedge clk);
    #2;
    spi_ss = 1'b1;
    n = 0;
    while (busy && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_busy_fall_1to3"}, {31'b0, (n >= 1 && n <= 3)}, 32'h1);
    chk({name, "_miso_oe_off"}, {31'b0, miso_oe}, 32'h0);
  endtask

  initial begin
    logic [31:0] junk;
    int unsigned acc0, n;

    vecs[0] = '{8'h02, 32'h20000010, 32'hDEADBEEF, 32'h0,        1, 1'b1, 32'h0};
    vecs[1] = '{8'h03, 32'h10000004, 32'h0,        32'h12345678, 1, 1'b0, 32'h12345678};
    vecs[2] = '{8'h55, 32'h20000010, 32'hDEADBEEF, 32'h0,        0, 1'b0, 32'h0};
    vecs[3] = '{8'h02, 32'h00000000, 32'hFFFFFFFF, 32'h0,        1, 1'b1, 32'h0};
    vecs[4] = '{8'h03, 32'hFFFFFFFC, 32'h0,        32'hA5A5A5A5, 1, 1'b0, 32'hA5A5A5A5};
    vecs[5] = '{8'h00, 32'h12345678, 32'h0,        32'h0,        0, 1'b0, 32'h0};
    vecs[6] = '{8'h03, 32'h0000ABCD, 32'h0,        32'h80000001, 1, 1'b0, 32'h80000001};
    vecs[7] = '{8'h02, 32'hFFFFFFFF, 32'h00000001, 32'h0,        1, 1'b1, 32'h0};
    vecs[8] = '{8'h04, 32'h10000004, 32'h0,        32'hFFFFFFFF, 0, 1'b0, 32'h0};

    gnt   = 1'b1;
    rdata = '0;

    // Reset state
    #12;
    chk("rst_req", {31'b0, req}, 32'h0);
    chk("rst_we", {31'b0, we}, 32'h0);
    chk("rst_busy", {31'b0, busy}, 32'h0);
    chk("rst_miso_oe", {31'b0, miso_oe}, 32'h0);
    chk("rst_miso", {31'b0, spi_miso}, 32'h0);
    chk("rst_addr", addr, 32'h0);
    chk("rst_wdata", wdata, 32'h0);
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);

    // Table of full frames
    for (int unsigned i = 0; i < 9; i++) apply_vec(i);

    // Invalid command, 72 SCK, then busy must drop shortly after SS rises
    @(negedge clk);
    acc0 = acc_cnt;
    spi_ss = 1'b0;
    #80;
    send_bits(32'h55, 8, junk);
    send_bits(32'hFFFFFFFF, 32, junk);
    send_bits(32'hFFFFFFFF, 32, junk);
    chk("badcmd_busy_during", {31'b0, busy}, 32'h1);
    measure_busy_fall("badcmd");
    chk("badcmd_accesses", acc_cnt - acc0, 0);

    // SS rises after 20 write-data bits: no bus access
    @(negedge clk);
    acc0 = acc_cnt;
    spi_ss = 1'b0;
    #80;
    send_bits(32'h02, 8, junk);
    send_bits(32'h30000000, 32, junk);
    send_bits(32'h000CAFE5, 20, junk);
    #80;
    measure_busy_fall("partial");
    repeat (10) @(negedge clk);
    chk("partial_accesses", acc_cnt - acc0, 0);
    chk("partial_req", {31'b0, req}, 32'h0);
    apply_vec(0);

    // Grant withheld while the write is pending and SS already released
    @(negedge clk);
    gnt = 1'b0;
    acc0 = acc_cnt;
    run_frame(8'h02, 32'h40000020, 32'h0BADF00D, junk, junk);
    repeat (80) @(negedge clk);
    chk("stall_req_held", {31'b0, req}, 32'h1);
    chk("stall_we_held", {31'b0, we}, 32'h1);
    chk("stall_addr_stable", addr, 32'h40000020);
    chk("stall_wdata_stable", wdata, 32'h0BADF00D);
    chk("stall_busy", {31'b0, busy}, 32'h1);
    chk("stall_no_access_yet", acc_cnt - acc0, 0);
    @(posedge clk);
    #2;
    gnt = 1'b1;
    n = 0;
    while (req && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("stall_req_dropped", {31'b0, req}, 32'h0);
    chk("stall_accesses", acc_cnt - acc0, 1);
    chk("stall_addr_at_gnt", mon_addr, 32'h40000020);
    chk("stall_idle_after", {31'b0, busy}, 32'h0);

    // Async reset in the middle of read data shifting
    @(negedge clk);
    rdata = 32'hFFFFFFFF;
    spi_ss = 1'b0;
    #80;
    send_bits(32'h03, 8, junk);
    send_bits(32'h50000008, 32, junk);
    send_bits('0, 8, junk);
    send_bits('0, 10, junk);
    #30;
    chk("midrd_miso_before_rst", {31'b0, spi_miso}, 32'h1);
    chk("midrd_busy_before_rst", {31'b0, busy}, 32'h1);
    #2;
    rst = 1'b0;
    #1;
    chk("midrd_rst_miso", {31'b0, spi_miso}, 32'h0);
    chk("midrd_rst_miso_oe", {31'b0, miso_oe}, 32'h0);
    chk("midrd_rst_busy", {31'b0, busy}, 32'h0);
    chk("midrd_rst_req", {31'b0, req}, 32'h0);
    chk("midrd_rst_addr", addr, 32'h0);
    chk("midrd_rst_wdata", wdata, 32'h0);
    spi_ss = 1'b1;
    #20;
    @(negedge clk);
    rst = 1'b1;
    repeat (5) @(negedge clk);
    chk("post_rst_idle", {31'b0, busy}, 32'h0);
    apply_vec(1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
